// File: rtl/dmem_responder_if.sv
// Core data-memory bus plus debug read port and buffer occupancy, as seen by dmem_responder.
interface dmem_responder_if #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
);
  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Data2Mem;
  logic [DATA_W-1:0] ReadDataMem;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic [CNT_W-1:0]  wbuf_count;

  modport master (
    output CEN, WEN, OEN, A, Data2Mem, dbg_req, dbg_addr,
    input  ReadDataMem, dbg_ack, dbg_rdata, wbuf_count
  );

  modport slave (
    input  CEN, WEN, OEN, A, Data2Mem, dbg_req, dbg_addr,
    output ReadDataMem, dbg_ack, dbg_rdata, wbuf_count
  );
endinterface

// File: rtl/dmem_responder.sv
// Data memory behind the MIPS core: posted write buffer draining into a word array,
// with a debug read port sharing the array port and forwarding from the buffer on both read paths.
module dmem_responder #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int MEM_D = 1 << ADDR_W;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} buf_state_e;

  logic [DATA_W-1:0] mem [MEM_D];

  logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
  logic [ADDR_W-1:0] wb_addr_d [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_d [WBUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  buf_state_e        state_q;

  logic enq, full, svc, drain;

  // Walk oldest to youngest so the last hit (youngest write) wins over the array.
  function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    logic [PTR_W-1:0]  idx;
    r = mem[a];
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && wb_addr_q[idx] == a) r = wb_data_q[idx];
    end
    return r;
  endfunction

  always_comb begin
    enq   = !bus.CEN && !bus.WEN;
    full  = (state_q == FULL);
    // A full buffer must drain so an enqueue at full never overflows.
    svc   = !full && bus.dbg_req && !dbg_ack_q;
    drain = full || (!svc && state_q != EMPTY);

    count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
    head_d  = head_q + PTR_W'(drain);
    tail_d  = tail_q + PTR_W'(enq);

    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (enq) begin
      wb_addr_d[tail_q] = bus.A;
      wb_data_d[tail_q] = bus.Data2Mem;
    end

    dbg_ack_d   = svc;
    dbg_rdata_d = svc ? lookup(bus.dbg_addr) : dbg_rdata_q;
  end

  always_comb begin
    bus.ReadDataMem = '0;
    if (!bus.CEN && !bus.OEN) bus.ReadDataMem = lookup(bus.A);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
      state_q     <= EMPTY;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
      if (count_d == '0)                      state_q <= EMPTY;
      else if (count_d == CNT_W'(WBUF_DEPTH)) state_q <= FULL;
      else                                    state_q <= PARTIAL;
    end
  end

  // Entry storage needs no reset: occupancy gates every use of it.
  always_ff @(posedge clk) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n && drain) mem[wb_addr_q[head_q]] <= wb_data_q[head_q];
  end

  assign bus.dbg_ack    = dbg_ack_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.wbuf_count = count_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + random bench for dmem_responder against a queue-based reference model.
module tb_dmem_responder;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(D)) bus();
  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] ref_mem [128];
  logic          ref_ack;
  logic [DW-1:0] ref_rdata;
  logic          cur_req;
  logic [AW-1:0] cur_da;
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Youngest pending write to the address, else the array.
  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].a == a) return q[i].d;
    return ref_mem[a];
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit cen, input bit wen, input bit oen, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit req, input logic [AW-1:0] da,
                      input bit rst, output logic [DW-1:0] rd);
    bit full, svc, drn;
    wr_t e;
    chk("count", 64'(bus.wbuf_count), 64'(q.size()));
    chk("ack", 64'(bus.dbg_ack), 64'(ref_ack));
    chk("rdata", 64'(bus.dbg_rdata), 64'(ref_rdata));
    bus.CEN = cen; bus.WEN = wen; bus.OEN = oen; bus.A = a; bus.Data2Mem = d;
    bus.dbg_req = req; bus.dbg_addr = da; rst_n = rst;
    #1;
    rd = bus.ReadDataMem;
    chk("rdm", 64'(rd), (!cen && !oen) ? 64'(ref_read(a)) : 64'd0);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      ref_ack = 1'b0;
      ref_rdata = '0;
    end else begin
      full = (q.size() == D);
      svc  = !full && req && !ref_ack;
      drn  = full || (!svc && q.size() > 0);
      if (svc) ref_rdata = ref_read(da);
      ref_ack = svc;
      if (drn) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (!cen && !wen) begin
        e.a = a; e.d = d;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    step(0, 0, 1, a, d, cur_req, cur_da, 1, r);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] r);
    step(0, 1, 0, a, '0, cur_req, cur_da, 1, r);
  endtask

  task automatic idle();
    logic [DW-1:0] r;
    step(1, 1, 1, '0, '0, cur_req, cur_da, 1, r);
  endtask

  task automatic dbg_rd(input logic [AW-1:0] da);
    bit got = 0;
    cur_req = 1; cur_da = da;
    for (int i = 0; i < 40 && !got; i++) begin
      idle();
      got = bus.dbg_ack;
    end
    cur_req = 0;
    chk("dbg_ack_seen", 64'(got), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] r;
    logic [5:0]    pat;
    int            maxc;
    rst_n = 0; bus.CEN = 1; bus.WEN = 1; bus.OEN = 1; bus.A = '0; bus.Data2Mem = '0;
    bus.dbg_req = 0; bus.dbg_addr = '0;
    cur_req = 0; cur_da = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete(); ref_ack = 0; ref_rdata = '0;
    rst_n = 1;

    // Give every array word a known value.
    for (int i = 0; i < 128; i++) wr(AW'(i), $urandom);
    repeat (3) idle();

    // Write then forward, then debug read.
    wr(5, 32'hDEADBEEF);
    rd(5, r); chk("fwd5", 64'(r), 64'hDEADBEEF);
    idle();
    dbg_rd(5); chk("dbg5", 64'(bus.dbg_rdata), 64'hDEADBEEF);

    // Same-address ordering.
    wr(3, 1); rd(3, r); chk("ord1", 64'(r), 64'd1);
    wr(3, 2); rd(3, r); chk("ord2", 64'(r), 64'd2);
    wr(3, 3); repeat (3) idle();
    dbg_rd(3); chk("ord3", 64'(bus.dbg_rdata), 64'd3);

    // Full-buffer arbitration with debug held.
    cur_req = 1; cur_da = 9; maxc = 0;
    for (int i = 0; i < 8; i++) begin
      wr(AW'(40 + i), DW'(100 + i));
      if (int'(bus.wbuf_count) > maxc) maxc = int'(bus.wbuf_count);
    end
    chk("sat", 64'(maxc), 64'd4);
    dbg_rd(9);
    repeat (6) idle();
    for (int i = 0; i < 8; i++) begin
      dbg_rd(AW'(40 + i)); chk("full_wr", 64'(bus.dbg_rdata), 64'(100 + i));
    end

    // No double service while req stays high.
    repeat (6) idle();
    cur_req = 1; cur_da = 12;
    for (int i = 0; i < 6; i++) begin idle(); pat[i] = bus.dbg_ack; end
    cur_req = 0;
    chk("nodbl", 64'(pat), 64'b010101);
    idle();

    // Read together with write returns the old value.
    wr(7, 32'h11); repeat (3) idle();
    step(0, 0, 0, 7, 32'h22, 0, 0, 1, r); chk("rww_old", 64'(r), 64'h11);
    rd(7, r); chk("rww_new", 64'(r), 64'h22);

    // Reset mid-operation.
    cur_req = 1; cur_da = 50;
    wr(20, 32'hAAAA0020); wr(21, 32'hAAAA0021); wr(22, 32'hAAAA0022);
    cur_req = 0;
    step(1, 1, 1, 0, 0, 1, 50, 0, r);
    chk("rst_cnt", 64'(bus.wbuf_count), 64'd0);
    chk("rst_ack", 64'(bus.dbg_ack), 64'd0);
    chk("rst_rdata", 64'(bus.dbg_rdata), 64'd0);
    for (int i = 20; i < 23; i++) rd(AW'(i), r);
    rd(21, r); chk("rst_lost", 64'(r == 32'hAAAA0021), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (!cur_req) begin
        if ($urandom_range(2) == 0) begin cur_req = 1; cur_da = AW'($urandom_range(15)); end
      end else if (bus.dbg_ack && $urandom_range(1) == 0) cur_req = 0;
      step($urandom_range(3) == 0, $urandom_range(1) == 0, $urandom_range(1) == 0,
           AW'($urandom_range(15)), $urandom, cur_req, cur_da, $urandom_range(99) != 0, r);
      if (!rst_n) cur_req = 0;
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
